sw_input_port: RTL and testbench
================================

Name: sw_input_port

Overview:
- Input-direction peripheral complementing the CPU's output port and 7-segment display path.
- Takes raw board switches (`sw_i`), synchronizes and debounces each bit, and captures rising/falling-edge events in sticky registers.
- Presents the debounced level, the event registers and an edge counter through a 1-cycle-latency read interface the CPU data path polls.

Parameters:
- `N`, 16, number of switch inputs (1..32).
- `DEB_CYCLES`, 1000000, consecutive stable cycles required before a debounced bit changes (≥2; benches use 4).
- `CNT_W`, `$clog2(DEB_CYCLES)`, width of each debounce counter.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `sw_i`  in  N  raw, asynchronous switch levels.
- `rd_en`  in  1  read strobe, sampled on the rising edge.
- `rd_addr`  in  2  register select: 0 level, 1 rise, 2 fall, 3 count.
- `rd_data`  out  32  registered read data, zero-extended above N.
- `rd_valid`  out  1  high for the one cycle after an accepted read.
- `level_o`  out  N  debounced switch levels, direct.

Behaviour:
- Reset (asynchronous, `rstn`=0): sync flops, `level_o`, debounce counters, `rise_sticky`, `fall_sticky`, `edge_cnt`, `rd_data` and `rd_valid` all go to 0. Reset mid-debounce discards partial counts.
- Synchronizer: 2-flop per bit; `s[i]` is the second-stage output.
- Debounce, per bit:
  - If `s[i]` == `level_o[i]`, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter == `DEB_CYCLES`-1 and `s[i]` still differs, `level_o[i]` flips and the counter clears on the same edge.
  - A glitch shorter than `DEB_CYCLES` cycles never changes `level_o`.
- Latency: `sw_i` first sampled high at edge k and held → `level_o` changes at edge k+`DEB_CYCLES`+1.
- Switches already high at reset release produce a normal debounced rise event; this is intended.
- Events:
  - A flip 0→1 sets `rise_sticky[i]` on the same edge as the `level_o` update; 1→0 sets `fall_sticky[i]`.
  - `edge_cnt` (32-bit) adds the popcount of rising flips in that cycle and wraps modulo 2^32.
- Read interface:
  - `rd_en`=1 at edge j → `rd_data` takes the selected register's pre-edge value and `rd_valid`=1 after edge j.
  - `rd_valid` returns to 0 on the next edge without `rd_en`.
  - `rd_data` holds its value when `rd_en`=0.
- Clear-on-read:
  - Reading address 1 clears `rise_sticky`; reading address 2 clears `fall_sticky`.
  - The sticky register becomes exactly the events arriving on the read edge, so an event coinciding with a read is never lost: it appears in the next read.
  - Addresses 0 and 3 have no side effects.
- Back-to-back reads on consecutive edges are legal; each returns the state at its own edge.

Optional Feature:
- Macro: `SW_PORT_IRQ_EN`.
- Defined: adds output port `irq_o` (1 bit), registered, reset 0. `irq_o` = OR of all `rise_sticky` and `fall_sticky` bits as they stand after the edge, so it drops one edge after the clearing read if no new event arrived.
- Undefined: no `irq_o` port, no extra logic; polling only.

Decomposition:
- Shared package `sw_port_pkg`:
  - address constants `SWP_ADDR_LEVEL`=0, `SWP_ADDR_RISE`=1, `SWP_ADDR_FALL`=2, `SWP_ADDR_CNT`=3;
  - default `DEB_CYCLES`.
- Sub-module `sw_debounce_bit`: 2-flop synchronizer + counter + level for one bit. It exposes `level` plus single-cycle `rise`/`fall` pulses. The top instantiates it N times and holds the sticky bits, the counter and the read mux.

Test Plan (`DEB_CYCLES`=4, N=16):
- **Debounce and rise event:** `sw_i[3]` 0→1 sampled at edge 10, held → `level_o[3]`=1 at edge 15; read addr 1 → `rd_data`=0x0000_0008, `rd_valid`=1 one cycle; an immediate second read of addr 1 → 0.
- **Glitch rejection:** `sw_i[0]` high for 3 cycles, then low → `level_o` remains 0; rise, fall and count reads all 0.
- **Multi-edge count:** `sw_i` 0x0000→0x00F0 held, then 0x0000, then 0x0010 → addr 3 reads 5, addr 2 reads 0x0000_00F0, addr 0 reads 0x0000_0010.
- **Event on clear edge:** time a read of addr 1 on the same edge `level_o[7]` rises → that read returns 0 for bit 7; the next read returns 0x0000_0080.
- **Reset mid-operation:** `rstn` low for 2 cycles with stickies set and a debounce in progress → all outputs 0 immediately. After release, held-high switches re-debounce and flag rise.
- **IRQ (`SW_PORT_IRQ_EN`):** `irq_o`=0 → rise on bit 1 → `irq_o`=1 one edge after the `level_o` update; read addr 1 → `irq_o`=0 the following edge.

Source files
------------

// File: rtl/sw_port_pkg.sv
// rtl/sw_port_pkg.sv - shared register map and defaults for the switch input port
package sw_port_pkg;

  localparam logic [1:0] SWP_ADDR_LEVEL = 2'd0;
  localparam logic [1:0] SWP_ADDR_RISE  = 2'd1;
  localparam logic [1:0] SWP_ADDR_FALL  = 2'd2;
  localparam logic [1:0] SWP_ADDR_CNT   = 2'd3;

  localparam int SWP_DEB_CYCLES = 1000000;

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - one switch bit: 2-flop synchronizer, stability counter, debounced level
module sw_debounce_bit
  import sw_port_pkg::*;
#(
  parameter int DEB_CYCLES = SWP_DEB_CYCLES,
  parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample matching the current level restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= sw_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_d & ~level_q;
  assign fall_o  = ~level_d & level_q;

endmodule

// File: rtl/sw_input_port.sv
// rtl/sw_input_port.sv - debounced switch port with sticky edge events, edge counter and polled reads
// Optional interrupt output irq_o when SW_PORT_IRQ_EN is defined.
module sw_input_port
  import sw_port_pkg::*;
#(
  parameter int N          = 16,
  parameter int DEB_CYCLES = SWP_DEB_CYCLES,
  parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] sw_i,
  input  logic         rd_en,
  input  logic [1:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic         rd_valid,
  output logic [N-1:0] level_o
`ifdef SW_PORT_IRQ_EN
  ,
  output logic         irq_o
`endif
);

  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;
  logic [N-1:0] rise_sticky_q, rise_sticky_d;
  logic [N-1:0] fall_sticky_q, fall_sticky_d;
  logic [31:0]  edge_cnt_q, edge_cnt_d;
  logic [31:0]  rise_pop;
  logic [31:0]  rd_data_q, rd_data_d;
  logic         rd_valid_q;

  for (genvar g = 0; g < N; g++) begin : g_bit
    sw_debounce_bit #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clk    (clk),
      .rstn   (rstn),
      .sw_i   (sw_i[g]),
      .level_o(level_o[g]),
      .rise_o (rise_pulse[g]),
      .fall_o (fall_pulse[g])
    );
  end

  // A clearing read keeps events landing on the same edge so none are lost.
  always_comb begin
    rise_sticky_d = rise_sticky_q | rise_pulse;
    fall_sticky_d = fall_sticky_q | fall_pulse;
    if (rd_en && (rd_addr == SWP_ADDR_RISE)) rise_sticky_d = rise_pulse;
    if (rd_en && (rd_addr == SWP_ADDR_FALL)) fall_sticky_d = fall_pulse;

    rise_pop = '0;
    for (int i = 0; i < N; i++) begin
      rise_pop = rise_pop + 32'(rise_pulse[i]);
    end
    edge_cnt_d = edge_cnt_q + rise_pop;

    rd_data_d = rd_data_q;
    if (rd_en) begin
      case (rd_addr)
        SWP_ADDR_LEVEL: rd_data_d = 32'(level_o);
        SWP_ADDR_RISE:  rd_data_d = 32'(rise_sticky_q);
        SWP_ADDR_FALL:  rd_data_d = 32'(fall_sticky_q);
        default:        rd_data_d = edge_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rise_sticky_q <= '0;
      fall_sticky_q <= '0;
      edge_cnt_q    <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      rise_sticky_q <= rise_sticky_d;
      fall_sticky_q <= fall_sticky_d;
      edge_cnt_q    <= edge_cnt_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_en;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef SW_PORT_IRQ_EN
  logic irq_q;

  // Follows the sticky registers one edge later, so it drops the edge after a clearing read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |{rise_sticky_q, fall_sticky_q};
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_sw_input_port.sv
// tb/tb_sw_input_port.sv - randomized scoreboard bench for sw_input_port against a windowed reference model
module tb_sw_input_port;
  import sw_port_pkg::*;

  localparam int N   = 16;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  sw_i = '0;
  logic          rd_en = 1'b0;
  logic [1:0]    rd_addr = 2'd0;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [N-1:0]  level_o;
`ifdef SW_PORT_IRQ_EN
  logic          irq_o;
`endif

  int checks = 0;
  int errors = 0;

  sw_input_port #(
    .N         (N),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .sw_i    (sw_i),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .level_o (level_o)
`ifdef SW_PORT_IRQ_EN
    ,
    .irq_o   (irq_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference: a bit flips once its last DEB synchronized samples all disagree with it.
  logic [N-1:0] m_lvl, m_rise, m_fall;
  logic [31:0]  m_cnt;
  logic         m_irq;
  logic [N-1:0] hist[$];
  logic [31:0]  exp_q[$];
  logic [31:0]  last_rd;
  logic [N-1:0] cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl  = '0;
    m_rise = '0;
    m_fall = '0;
    m_cnt  = '0;
    m_irq  = 1'b0;
    hist.delete();
    repeat (DEB + 1) hist.push_back('0);
    exp_q.delete();
    last_rd = '0;
  endtask

  task automatic model_step(input logic [N-1:0] sw, input logic en, input logic [1:0] addr);
    logic [N-1:0] nl, rises, falls;
    logic all_diff;
    if (en) begin
      case (addr)
        2'd0:    exp_q.push_back(32'(m_lvl));
        2'd1:    exp_q.push_back(32'(m_rise));
        2'd2:    exp_q.push_back(32'(m_fall));
        default: exp_q.push_back(m_cnt);
      endcase
    end
    nl = m_lvl;
    for (int i = 0; i < N; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) if (hist[j][i] == m_lvl[i]) all_diff = 1'b0;
      if (all_diff) nl[i] = ~m_lvl[i];
    end
    rises  = nl & ~m_lvl;
    falls  = ~nl & m_lvl;
    m_irq  = |(m_rise | m_fall);
    m_rise = (en && addr == 2'd1) ? rises : (m_rise | rises);
    m_fall = (en && addr == 2'd2) ? falls : (m_fall | falls);
    m_cnt  = m_cnt + 32'($countones(rises));
    m_lvl  = nl;
    hist.push_back(sw);
    void'(hist.pop_front());
  endtask

  task automatic cycle(input logic [N-1:0] sw, input logic en, input logic [1:0] addr);
    sw_i    = sw;
    rd_en   = en;
    rd_addr = addr;
    @(posedge clk);
    model_step(sw, en, addr);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) cycle(cur, 1'b0, 2'd0);
  endtask

  task automatic rd(input logic [1:0] addr);
    cycle(cur, 1'b1, addr);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_level", 32'(level_o), 32'h0);
`ifdef SW_PORT_IRQ_EN
    chk("rst_irq", 32'(irq_o), 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rstn) begin
      chk("level", 32'(level_o), 32'(m_lvl));
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rd_valid", 32'(rd_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
          last_rd = e;
        end
      end else begin
        if (exp_q.size() != 0) begin
          chk("missing_rd_valid", 32'(rd_valid), 32'h1);
          exp_q.delete();
        end
        chk("rd_hold", rd_data, last_rd);
      end
`ifdef SW_PORT_IRQ_EN
      chk("irq", 32'(irq_o), 32'(m_irq));
`endif
    end
  end

  initial begin
    model_reset();
    cur = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_rd_data", rd_data, 32'h0);
    chk("init_rd_valid", 32'(rd_valid), 32'h0);
    chk("init_level", 32'(level_o), 32'h0);
    rstn = 1'b1;
    hold(4);

    // Debounce latency and rise event on bit 3
    cur = 16'h0008;
    hold(4);
    cycle(cur, 1'b0, 2'd0);
    chk("deb_before", 32'(level_o), 32'h0);
    cycle(cur, 1'b0, 2'd0);
    chk("deb_after", 32'(level_o), 32'h8);
    hold(2);
    rd(2'd1);
    rd(2'd1);
    hold(2);

    // Glitch on bit 0 shorter than the debounce window
    cycle(cur | 16'h1, 1'b0, 2'd0);
    cycle(cur | 16'h1, 1'b0, 2'd0);
    cycle(cur | 16'h1, 1'b0, 2'd0);
    hold(8);
    chk("glitch_level", 32'(level_o), 32'h8);
    rd(2'd1); rd(2'd2); rd(2'd3);

    // Multi-edge counting
    cur = 16'h0000; hold(8); rd(2'd2);
    cur = 16'h00F0; hold(8);
    cur = 16'h0000; hold(8);
    cur = 16'h0010; hold(8);
    rd(2'd3); rd(2'd2); rd(2'd0); rd(2'd1);

    // Event landing on the clearing read edge
    cur = 16'h0090;
    cycle(cur, 1'b0, 2'd0);
    hold(3);
    cycle(cur, 1'b0, 2'd0);
    rd(2'd1);
    chk("coincide_level", 32'(level_o), 32'h90);
    rd(2'd1);
    hold(2);

    // Reset in the middle of a debounce with stickies set
    cur = 16'hFFFF;
    hold(3);
    do_reset();
    hold(8);
    rd(2'd1); rd(2'd3); rd(2'd1);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) cur = cur ^ N'($urandom & $urandom & $urandom);
      if (n == 1500) do_reset();
      cycle(cur, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
    end
    hold(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
